// File: rtl/snake_mover.sv
// Snake body keeper and world-memory writer: per game step it moves the head,
// checks walls and self-collision, then erases the vacated tail and paints the new head.
module snake_mover #(
   parameter int GRID    = 15,
   parameter int MAX_LEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic [1:0] dir,
   input  logic       grow,
   output logic       busy,
   output logic       game_over,
   output logic [5:0] length,
   output logic       writeEnable,
   output logic [1:0] wr_data,
   output logic [4:0] x_loc_sw,
   output logic [4:0] y_loc_sw
);
   localparam int PW = $clog2(MAX_LEN);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ERASE, S_WRITE, S_DEAD} state_t;
   state_t r_state, w_next_state;

   logic [3:0]    r_body_x [MAX_LEN];
   logic [3:0]    r_body_y [MAX_LEN];
   logic [PW-1:0] r_head, r_tail;
   logic [5:0]    r_len, r_scan_cnt;
   logic [1:0]    r_dir;
   logic [3:0]    r_nx, r_ny;
   logic          r_grow, r_hit;
   logic          r_busy, r_game_over, r_we;
   logic [1:0]    r_wr_data;
   logic [4:0]    r_x, r_y;

   logic [1:0]    w_eff_dir;
   logic [4:0]    w_cand_x, w_cand_y;
   logic          w_cand_ok;
   logic [PW:0]   w_scan_sum;
   logic [PW-1:0] w_scan_idx, w_head_nxt, w_tail_nxt;
   logic          w_scan_last, w_match;

   assign busy        = r_busy;
   assign game_over   = r_game_over;
   assign length      = r_len;
   assign writeEnable = r_we;
   assign wr_data     = r_wr_data;
   assign x_loc_sw    = r_x;
   assign y_loc_sw    = r_y;

   assign w_head_nxt = (r_head == PW'(MAX_LEN - 1)) ? '0 : r_head + 1'b1;
   assign w_tail_nxt = (r_tail == PW'(MAX_LEN - 1)) ? '0 : r_tail + 1'b1;

   // Scan walks tail->head; the index wraps around the circular buffer.
   assign w_scan_sum  = {1'b0, r_tail} + (PW+1)'(r_scan_cnt);
   assign w_scan_idx  = (w_scan_sum >= (PW+1)'(MAX_LEN)) ?
                        PW'(w_scan_sum - (PW+1)'(MAX_LEN)) : w_scan_sum[PW-1:0];
   assign w_scan_last = (r_scan_cnt == r_len - 6'd1);
   assign w_match     = (r_body_x[w_scan_idx] == r_nx) && (r_body_y[w_scan_idx] == r_ny) &&
                        (r_grow || (r_scan_cnt != 6'd0));

   always_comb begin
      w_next_state = r_state;
      w_eff_dir    = ((dir ^ r_dir) == 2'b10) ? r_dir : dir;
      w_cand_x     = {1'b0, r_body_x[r_head]};
      w_cand_y     = {1'b0, r_body_y[r_head]};
      case (w_eff_dir)
         2'b00:   w_cand_x = {1'b0, r_body_x[r_head]} + 5'd1;
         2'b01:   w_cand_y = {1'b0, r_body_y[r_head]} + 5'd1;
         2'b10:   w_cand_x = {1'b0, r_body_x[r_head]} - 5'd1;
         default: w_cand_y = {1'b0, r_body_y[r_head]} - 5'd1;
      endcase
      w_cand_ok = (w_cand_x >= 5'd1) && (w_cand_x <= 5'(GRID)) &&
                  (w_cand_y >= 5'd1) && (w_cand_y <= 5'(GRID));
      case (r_state)
         S_IDLE:  if (step) w_next_state = w_cand_ok ? S_CHECK : S_DEAD;
         S_CHECK: if (w_scan_last)
                     w_next_state = (r_hit || w_match) ? S_DEAD : (r_grow ? S_WRITE : S_ERASE);
         S_ERASE: w_next_state = S_WRITE;
         S_WRITE: w_next_state = S_IDLE;
         default: w_next_state = S_DEAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            r_body_x[i] <= '0;
            r_body_y[i] <= '0;
         end
         r_body_x[0] <= 4'd1; r_body_y[0] <= 4'd1;
         r_body_x[1] <= 4'd2; r_body_y[1] <= 4'd1;
         r_body_x[2] <= 4'd3; r_body_y[2] <= 4'd1;
         r_tail     <= '0;
         r_head     <= PW'(2);
         r_len      <= 6'd3;
         r_dir      <= 2'b00;
         r_nx       <= '0;
         r_ny       <= '0;
         r_grow     <= 1'b0;
         r_hit      <= 1'b0;
         r_scan_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (step) begin
               r_dir      <= w_eff_dir;
               r_nx       <= w_cand_x[3:0];
               r_ny       <= w_cand_y[3:0];
               // A full buffer cannot lengthen, so growth degrades to a plain move.
               r_grow     <= grow && (r_len != 6'(MAX_LEN));
               r_hit      <= 1'b0;
               r_scan_cnt <= '0;
            end
            S_CHECK: begin
               r_scan_cnt <= r_scan_cnt + 6'd1;
               r_hit      <= r_hit | w_match;
            end
            S_ERASE: r_tail <= w_tail_nxt;
            S_WRITE: begin
               r_head               <= w_head_nxt;
               r_body_x[w_head_nxt] <= r_nx;
               r_body_y[w_head_nxt] <= r_ny;
               if (r_grow) r_len <= r_len + 6'd1;
            end
            default: ;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy      <= 1'b0;
         r_game_over <= 1'b0;
         r_we        <= 1'b0;
         r_wr_data   <= 2'b00;
         r_x         <= '0;
         r_y         <= '0;
      end else begin
         r_busy      <= (w_next_state == S_CHECK) || (w_next_state == S_ERASE) ||
                        (w_next_state == S_WRITE);
         r_game_over <= (w_next_state == S_DEAD);
         r_we        <= (w_next_state == S_ERASE) || (w_next_state == S_WRITE);
         if (w_next_state == S_ERASE) begin
            r_wr_data <= 2'b00;
            r_x       <= {1'b0, r_body_x[r_tail]};
            r_y       <= {1'b0, r_body_y[r_tail]};
         end else if (w_next_state == S_WRITE) begin
            r_wr_data <= 2'b10;
            r_x       <= {1'b0, r_nx};
            r_y       <= {1'b0, r_ny};
         end
      end
   end
endmodule

// File: tb/tb_snake_mover.sv
// Bench for snake_mover: a queue-based snake model predicts every output cycle,
// plus literal checks pinning key moves from hand-worked games.
module tb_snake_mover;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       step = 1'b0;
   logic [1:0] dir = 2'b00;
   logic       grow = 1'b0;
   logic       busy, game_over, writeEnable;
   logic [5:0] length;
   logic [1:0] wr_data;
   logic [4:0] x_loc_sw, y_loc_sw;

   always #5 clk = ~clk;

   snake_mover dut (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
      .busy(busy), .game_over(game_over), .length(length),
      .writeEnable(writeEnable), .wr_data(wr_data),
      .x_loc_sw(x_loc_sw), .y_loc_sw(y_loc_sw)
   );

   typedef struct packed {
      logic       busy;
      logic       we;
      logic [1:0] data;
      logic [4:0] x;
      logic [4:0] y;
      logic       go;
      logic [5:0] len;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // model state: body as a tail-first coordinate list
   int   bx[$];
   int   by[$];
   int   m_dir;
   bit   m_go;
   exp_t m_cur;

   // observed events, written only by the compare process
   int busy_cnt = 0, erase_cnt = 0, write_cnt = 0, cyc = 0;
   int last_ex = 0, last_ey = 0, last_wx = 0, last_wy = 0, last_et = 0, last_wt = 0;

   task automatic check_lit(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      bx = '{1, 2, 3};
      by = '{1, 1, 1};
      m_dir = 0;
      m_go  = 1'b0;
      m_cur = '0;
      m_cur.len = 6'd3;
      exp_q.delete();
      exp_q.push_back(m_cur);
   endtask

   task automatic model_step(input int d, input bit g);
      int eff, hx, hy, nx, ny, len0;
      bit eg, hit;
      exp_t e;
      if (m_go) return;
      eff = ((d ^ m_dir) == 2) ? m_dir : d;
      m_dir = eff;
      hx = bx[bx.size()-1];
      hy = by[by.size()-1];
      nx = hx + ((eff == 0) ? 1 : 0) - ((eff == 2) ? 1 : 0);
      ny = hy + ((eff == 1) ? 1 : 0) - ((eff == 3) ? 1 : 0);
      if (nx < 1 || nx > 15 || ny < 1 || ny > 15) begin
         m_go = 1'b1;
         m_cur.go = 1'b1;
         exp_q.push_back(m_cur);
         return;
      end
      len0 = bx.size();
      eg   = g && (len0 < 32);
      hit  = 1'b0;
      for (int i = (eg ? 0 : 1); i < len0; i++)
         if (bx[i] == nx && by[i] == ny) hit = 1'b1;
      e = m_cur;
      e.busy = 1'b1;
      repeat (len0) exp_q.push_back(e);
      if (hit) begin
         m_go = 1'b1;
         m_cur.go = 1'b1;
         exp_q.push_back(m_cur);
         return;
      end
      if (!eg) begin
         e.we = 1'b1; e.data = 2'b00; e.x = 5'(bx[0]); e.y = 5'(by[0]);
         exp_q.push_back(e);
         void'(bx.pop_front());
         void'(by.pop_front());
      end
      e.we = 1'b1; e.data = 2'b10; e.x = 5'(nx); e.y = 5'(ny);
      exp_q.push_back(e);
      bx.push_back(nx);
      by.push_back(ny);
      m_cur.x = 5'(nx); m_cur.y = 5'(ny); m_cur.data = 2'b10;
      m_cur.len = 6'(bx.size());
      exp_q.push_back(m_cur);
   endtask

   // compare process: every falling edge the DUT must match the model's prediction
   initial begin
      exp_t hold, act;
      hold = '0;
      hold.len = 6'd3;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) hold = exp_q.pop_front();
         act = {busy, writeEnable, wr_data, x_loc_sw, y_loc_sw, game_over, length};
         n_vec++;
         if (act !== hold) begin
            n_bad++;
            $display("FAIL cycle@%0t busy/we/data/x/y/go/len got %0d/%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                     $time, act.busy, act.we, act.data, act.x, act.y, act.go, act.len,
                     hold.busy, hold.we, hold.data, hold.x, hold.y, hold.go, hold.len);
         end
         if (busy) busy_cnt++;
         if (writeEnable && wr_data == 2'b00) begin
            erase_cnt++; last_ex = x_loc_sw; last_ey = y_loc_sw; last_et = cyc;
         end
         if (writeEnable && wr_data == 2'b10) begin
            write_cnt++; last_wx = x_loc_sw; last_wy = y_loc_sw; last_wt = cyc;
         end
      end
   end

   task automatic start_step(input int d, input bit g);
      @(negedge clk); #1;
      dir = 2'(d); grow = g; step = 1'b1;
      model_step(d, g);
      @(negedge clk); #1;
      step = 1'b0; grow = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) check_lit("wait_idle_timeout", 0, 1);
   endtask

   task automatic do_step(input int d, input bit g);
      start_step(d, g);
      wait_idle();
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      int b0, e0, w0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_lit("reset_busy", busy, 0);
      check_lit("reset_we", writeEnable, 0);
      check_lit("reset_go", game_over, 0);
      check_lit("reset_len", length, 3);
      check_lit("reset_x", x_loc_sw, 0);
      rst = 1'b1;

      // 1: plain move right
      b0 = busy_cnt; e0 = erase_cnt;
      do_step(0, 0);
      check_lit("t1_busy_cycles", busy_cnt - b0, 5);
      check_lit("t1_erases", erase_cnt - e0, 1);
      check_lit("t1_erase_x", last_ex, 1);
      check_lit("t1_erase_y", last_ey, 1);
      check_lit("t1_write_x", last_wx, 4);
      check_lit("t1_write_y", last_wy, 1);
      check_lit("t1_len", length, 3);

      // 2: reversal keeps heading right, then turn down
      do_step(2, 0);
      check_lit("t2_erase_x", last_ex, 2);
      check_lit("t2_write_x", last_wx, 5);
      check_lit("t2_write_y", last_wy, 1);
      do_step(1, 0);
      check_lit("t2b_write_x", last_wx, 5);
      check_lit("t2b_write_y", last_wy, 2);

      // 3: grow adds a head without erasing
      b0 = busy_cnt; e0 = erase_cnt;
      do_step(1, 1);
      check_lit("t3_busy_cycles", busy_cnt - b0, 4);
      check_lit("t3_erases", erase_cnt - e0, 0);
      check_lit("t3_write_y", last_wy, 3);
      check_lit("t3_len", length, 4);

      // 4: wall hit going up from row 1
      do_reset();
      w0 = write_cnt;
      do_step(3, 0);
      check_lit("t4_go", game_over, 1);
      do_step(0, 0);
      do_step(1, 1);
      repeat (6) @(negedge clk);
      #1;
      check_lit("t4_writes", write_cnt - w0, 0);
      check_lit("t4_len", length, 3);
      check_lit("t4_go_held", game_over, 1);

      // 4b: reset drops a sticky game_over at once
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check_lit("t4_rst_go", game_over, 0);
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;

      // 5: head chases the vacating tail around a 2x2 square
      do_step(1, 1);
      do_step(2, 0);
      e0 = erase_cnt; w0 = write_cnt;
      do_step(3, 0);
      check_lit("t5_go", game_over, 0);
      check_lit("t5_erase_x", last_ex, 2);
      check_lit("t5_erase_y", last_ey, 1);
      check_lit("t5_write_x", last_wx, 2);
      check_lit("t5_write_y", last_wy, 1);
      check_lit("t5_erase_before_write", (last_et < last_wt) ? 1 : 0, 1);
      check_lit("t5_pair", (erase_cnt - e0) * 10 + (write_cnt - w0), 11);

      // 5b: same path while growing bites the tail
      do_reset();
      do_step(1, 1);
      do_step(2, 0);
      w0 = write_cnt;
      do_step(3, 1);
      check_lit("t5b_go", game_over, 1);
      check_lit("t5b_writes", write_cnt - w0, 0);
      check_lit("t5b_len", length, 4);

      // 6: step during CHECK is dropped
      do_reset();
      e0 = erase_cnt; w0 = write_cnt;
      start_step(0, 0);
      @(negedge clk); #1;
      dir = 2'b01; step = 1'b1;
      @(negedge clk); #1;
      step = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      #1;
      check_lit("t6_erases", erase_cnt - e0, 1);
      check_lit("t6_writes", write_cnt - w0, 1);
      check_lit("t6_write_x", last_wx, 4);

      // 6b: reset in the middle of CHECK on a length-4 snake
      do_step(0, 1);
      check_lit("t6b_len_grown", length, 4);
      start_step(1, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check_lit("t6b_busy", busy, 0);
      check_lit("t6b_we", writeEnable, 0);
      check_lit("t6b_go", game_over, 0);
      check_lit("t6b_len", length, 3);
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      do_step(0, 0);
      check_lit("t6b_after_write_x", last_wx, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
